pc_unit: RTL and testbench

- Parametrised program-counter unit. Successor to the plain 8-bit PC register.
- Adds sequential increment, stall, branch, jump, call and return.
- Includes a circular return-address stack (RAS) and sticky stack-error flags.
- Sits at the head of the fetch stage and drives the instruction-memory address.

---
 rtl/pc_pkg.sv | 15 +
 rtl/pc_unit_ras_stack.sv | 54 +++++
 rtl/pc_unit.sv | 53 +++++
 tb/tb_pc_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared defaults and next-PC select encoding for the PC unit
package pc_pkg;
  localparam int PC_WIDTH_DEF = 8;
  localparam int STEP_DEF = 4;
  localparam int RAS_DEPTH_DEF = 4;
  localparam int RESET_PC_DEF = 0;
  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_RET,
    SEL_CALL,
    SEL_JUMP,
    SEL_BRANCH,
    SEL_SEQ
  } pc_sel_e;
endpackage

// File: rtl/pc_unit_ras_stack.sv
// ras_stack: circular return-address stack with saturating count and sticky error flags
module ras_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] sp_q, sp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic full, empty;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign top = mem_q[sp_q - 1'b1];
  assign count = cnt_q;
  assign overflow = ovf_q;
  assign underflow = unf_q;
  // sp points at the next free slot; when full that slot holds the oldest entry, so a push overwrites it
  always_comb begin
    sp_d = pop ? (empty ? sp_q : sp_q - 1'b1) : push ? sp_q + 1'b1 : sp_q;
    cnt_d = pop ? (empty ? cnt_q : cnt_q - 1'b1) : push ? (full ? cnt_q : cnt_q + 1'b1) : cnt_q;
    ovf_d = ovf_q | (push & ~pop & full);
    unf_d = unf_q | (pop & empty);
  end
  // pointer, count and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  // entry storage needs no reset; only count decides what is valid
  always_ff @(posedge clk) begin
    if (!rst && push && !pop) mem_q[sp_q] <= push_data;
  end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with stall, branch, jump, call/return and a return-address stack
module pc_unit
  import pc_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF,
  parameter int STEP = STEP_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic                             branch_taken,
  input  logic                             jump,
  input  logic                             call,
  input  logic                             ret,
  input  logic [PC_WIDTH-1:0]              target,
  output logic [PC_WIDTH-1:0]              pc_out,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_overflow,
  output logic                             ras_underflow
);
  pc_sel_e sel;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc, ras_top;
  logic push, pop;
  assign pc_inc = pc_q + PC_WIDTH'(STEP);
  assign pc_out = pc_q;
  // priority select; the stack only moves on the winning call or ret, so stalled or shadowed calls never push
  always_comb begin
    sel = stall ? SEL_HOLD : ret ? SEL_RET : call ? SEL_CALL : jump ? SEL_JUMP : branch_taken ? SEL_BRANCH : SEL_SEQ;
    push = sel == SEL_CALL;
    pop = sel == SEL_RET;
    pc_d = sel == SEL_HOLD ? pc_q :
           sel == SEL_RET ? (ras_count != '0 ? ras_top : pc_inc) :
           sel == SEL_SEQ ? pc_inc : target;
  end
  // PC register
  always_ff @(posedge clk) begin
    if (rst) pc_q <= PC_WIDTH'(RESET_PC);
    else pc_q <= pc_d;
  end
  ras_stack #(.WIDTH(PC_WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .push_data(pc_inc),
    .top(ras_top),
    .count(ras_count),
    .overflow(ras_overflow),
    .underflow(ras_underflow)
  );
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed checks of PC sequencing, redirects, stack behaviour and reset
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst, stall, branch_taken, jump, call, ret;
  logic [7:0] target;
  logic [7:0] pc_out;
  logic [2:0] ras_count;
  logic ras_overflow, ras_underflow;
  logic [12:0] obs;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  assign obs = {pc_out, ras_count, ras_overflow, ras_underflow};
  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken), .jump(jump),
    .call(call), .ret(ret), .target(target), .pc_out(pc_out), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );
  task automatic cyc(input logic rs, input logic st, input logic br, input logic jp,
                     input logic cl, input logic rt, input logic [7:0] tg);
    rst = rs; stall = st; branch_taken = br; jump = jp; call = cl; ret = rt; target = tg;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    logic [12:0] e;
    cyc(1, 0, 0, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 0, 8'h00);
    e = {8'h00, 3'd0, 2'b00};
    if (obs !== e) begin n_err++; $display("FAIL reset got={pc,cnt,ovf,unf}=%h exp=%h", obs, e); end
    n_cmp++;
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 8'h00);
      e = {8'(i * 4), 3'd0, 2'b00};
      if (obs !== e) begin n_err++; $display("FAIL freerun_%0d got=%h exp=%h", i, obs, e); end
      n_cmp++;
    end
  endtask
  task automatic test_wrap;
    logic [7:0] exp_pc [4] = '{8'hF8, 8'hFC, 8'h00, 8'h04};
    logic [12:0] e;
    cyc(0, 0, 0, 1, 0, 0, 8'hF8);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc(0, 0, 0, 0, 0, 0, 8'h00);
      e = {exp_pc[i], 3'd0, 2'b00};
      if (obs !== e) begin n_err++; $display("FAIL wrap_%0d got=%h exp=%h", i, obs, e); end
      n_cmp++;
    end
  endtask
  task automatic test_call_ret;
    logic [12:0] e;
    cyc(0, 0, 0, 1, 0, 0, 8'h10);
    cyc(0, 0, 0, 0, 1, 0, 8'h40);
    e = {8'h40, 3'd1, 2'b00};
    if (obs !== e) begin n_err++; $display("FAIL call got=%h exp=%h", obs, e); end
    n_cmp++;
    cyc(0, 0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 0, 8'h00);
    e = {8'h48, 3'd1, 2'b00};
    if (obs !== e) begin n_err++; $display("FAIL call_idle got=%h exp=%h", obs, e); end
    n_cmp++;
    cyc(0, 0, 0, 0, 0, 1, 8'h00);
    e = {8'h14, 3'd0, 2'b00};
    if (obs !== e) begin n_err++; $display("FAIL ret got=%h exp=%h", obs, e); end
    n_cmp++;
  endtask
  task automatic test_overflow_underflow;
    logic [7:0] tg [5] = '{8'h20, 8'h40, 8'h60, 8'h80, 8'hA0};
    logic [7:0] rp [4] = '{8'h84, 8'h64, 8'h44, 8'h24};
    logic [12:0] e;
    cyc(1, 0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 0, tg[i]);
    e = {8'hA0, 3'd4, 2'b10};
    if (obs !== e) begin n_err++; $display("FAIL overflow got=%h exp=%h", obs, e); end
    n_cmp++;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 8'h00);
      e = {rp[i], 3'(3 - i), 2'b10};
      if (obs !== e) begin n_err++; $display("FAIL pop_%0d got=%h exp=%h", i, obs, e); end
      n_cmp++;
    end
    cyc(0, 0, 0, 0, 0, 1, 8'h00);
    e = {8'h28, 3'd0, 2'b11};
    if (obs !== e) begin n_err++; $display("FAIL underflow got=%h exp=%h", obs, e); end
    n_cmp++;
  endtask
  task automatic test_stall;
    logic [12:0] e;
    cyc(1, 0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 1, 0, 0, 8'h30);
    cyc(0, 1, 0, 0, 1, 0, 8'h80);
    e = {8'h30, 3'd0, 2'b00};
    if (obs !== e) begin n_err++; $display("FAIL stall_call got=%h exp=%h", obs, e); end
    n_cmp++;
    cyc(0, 0, 0, 0, 1, 0, 8'h50);
    cyc(0, 1, 0, 0, 0, 1, 8'h00);
    e = {8'h50, 3'd1, 2'b00};
    if (obs !== e) begin n_err++; $display("FAIL stall_ret got=%h exp=%h", obs, e); end
    n_cmp++;
    cyc(0, 0, 0, 0, 1, 1, 8'h90);
    e = {8'h34, 3'd0, 2'b00};
    if (obs !== e) begin n_err++; $display("FAIL call_ret got=%h exp=%h", obs, e); end
    n_cmp++;
    cyc(0, 0, 0, 0, 0, 1, 8'h00);
    e = {8'h38, 3'd0, 2'b01};
    if (obs !== e) begin n_err++; $display("FAIL call_ret_nopush got=%h exp=%h", obs, e); end
    n_cmp++;
  endtask
  task automatic test_redirect_priority;
    logic [12:0] e;
    cyc(1, 0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 0, 8'h70);
    e = {8'h70, 3'd0, 2'b00};
    if (obs !== e) begin n_err++; $display("FAIL branch got=%h exp=%h", obs, e); end
    n_cmp++;
    cyc(0, 0, 1, 1, 1, 0, 8'hC0);
    e = {8'hC0, 3'd1, 2'b00};
    if (obs !== e) begin n_err++; $display("FAIL call_over_jump got=%h exp=%h", obs, e); end
    n_cmp++;
    cyc(0, 0, 0, 0, 0, 1, 8'h00);
    e = {8'h74, 3'd0, 2'b00};
    if (obs !== e) begin n_err++; $display("FAIL call_over_jump_ret got=%h exp=%h", obs, e); end
    n_cmp++;
  endtask
  task automatic test_reset_mid;
    logic [12:0] e;
    cyc(1, 0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 0, 8'h10);
    cyc(0, 0, 0, 0, 0, 1, 8'h00);
    e = {8'h14, 3'd3, 2'b10};
    if (obs !== e) begin n_err++; $display("FAIL pre_reset got=%h exp=%h", obs, e); end
    n_cmp++;
    cyc(1, 0, 0, 0, 1, 0, 8'h55);
    e = {8'h00, 3'd0, 2'b00};
    if (obs !== e) begin n_err++; $display("FAIL reset_mid got=%h exp=%h", obs, e); end
    n_cmp++;
    cyc(0, 0, 0, 0, 0, 1, 8'h00);
    e = {8'h04, 3'd0, 2'b01};
    if (obs !== e) begin n_err++; $display("FAIL reset_then_ret got=%h exp=%h", obs, e); end
    n_cmp++;
  endtask
  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0; target = 8'h00;
    test_reset;
    test_wrap;
    test_call_ret;
    test_overflow_underflow;
    test_stall;
    test_redirect_priority;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
